// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles every non-clock signal of regfile_write_arbiter: the two write
// requesters, the register-set write port, the read-address pass-through,
// the read-data return path, and the arbiter's priority pointer for debug.
//
// Modports
//   slave  : the arbiter side (consumes requests, drives the register set).
//   master : the environment side (requesters, reader, register set).
//
// Handshake: a request transfers on the cycle where reqN_valid and reqN_ready
// are both high. ready is a combinational function of the valids and the
// priority pointer. A requester that sees ready=0 keeps its request held
// (or may drop it, in which case nothing is written).
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 2
);
    // requester 0
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    // requester 1
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    // register-set write port
    logic [ADDR_W-1:0] Wr;
    logic [DATA_W-1:0] Wrd;
    logic              reg_en;
    // read addresses: reader -> arbiter -> register set
    logic [ADDR_W-1:0] Ra_in;
    logic [ADDR_W-1:0] Rb_in;
    logic [ADDR_W-1:0] Ra;
    logic [ADDR_W-1:0] Rb;
    // read data: register set -> arbiter -> reader
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    // priority pointer (0 = PRI0, 1 = PRI1)
    logic              pri_dbg;

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  Ra_in, Rb_in, a_in, b_in,
        output req0_ready, req1_ready,
        output Wr, Wrd, reg_en,
        output Ra, Rb, a, b,
        output pri_dbg
    );

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output Ra_in, Rb_in, a_in, b_in,
        input  req0_ready, req1_ready,
        input  Wr, Wrd, reg_en,
        input  Ra, Rb, a, b,
        input  pri_dbg
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates two write requesters onto the single write port of a register
// set using a one-bit round-robin pointer, and passes the reader's address
// and data paths through to / from the register set.
//
// Ports
//   clk  : single clock, all state updates on the rising edge.
//   rst  : synchronous, active-high reset.
//   bus  : regfile_write_arbiter_if.slave (requests, write port, read paths,
//          pri_dbg = current priority pointer).
//
// Behaviour
//   - One valid requester is granted regardless of the pointer; with both
//     valid the pointer names the winner. After any grant the pointer moves
//     to the other requester.
//   - The accepted addr/data appear on Wr/Wrd with reg_en=1 one cycle later;
//     Wr/Wrd hold their values while reg_en=0.
//   - While rst is high neither requester is granted.
//
// Configuration
//   WR_BYPASS_EN : when defined, read data a/b are forwarded from Wrd when the
//                  write being presented targets Ra_in/Rb_in. Undefined
//                  (default): a/b are a_in/b_in unchanged.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W = 5,
    parameter int ADDR_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

    pri_e              pri_q;
    logic              reg_en_q;
    logic [ADDR_W-1:0] wr_q;
    logic [DATA_W-1:0] wrd_q;

    logic grant0;
    logic grant1;

    // Grants are exclusive by construction: with both valid exactly one of
    // the pointer terms is true. rst blocks acceptance entirely.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || (pri_q == PRI0));
            grant1 = bus.req1_valid && (!bus.req0_valid || (pri_q == PRI1));
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Pointer and write port share one registered state block. A write that
    // is on the port when rst rises stays visible for that cycle only, since
    // reg_en is a register cleared at the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q    <= PRI0;
            reg_en_q <= 1'b0;
            wr_q     <= '0;
            wrd_q    <= '0;
        end else begin
            reg_en_q <= grant0 || grant1;
            if (grant0) begin
                wr_q  <= bus.req0_addr;
                wrd_q <= bus.req0_data;
                pri_q <= PRI1;
            end else if (grant1) begin
                wr_q  <= bus.req1_addr;
                wrd_q <= bus.req1_data;
                pri_q <= PRI0;
            end
        end
    end

    assign bus.reg_en  = reg_en_q;
    assign bus.Wr      = wr_q;
    assign bus.Wrd     = wrd_q;
    assign bus.pri_dbg = (pri_q == PRI1);

    // Read addresses go straight through with no latency.
    assign bus.Ra = bus.Ra_in;
    assign bus.Rb = bus.Rb_in;

`ifdef WR_BYPASS_EN
    // The register set commits Wrd at the end of the reg_en cycle, so a read
    // of the same address in that cycle would otherwise return stale data.
    assign bus.a = (reg_en_q && (bus.Ra_in == wr_q)) ? wrd_q : bus.a_in;
    assign bus.b = (reg_en_q && (bus.Rb_in == wr_q)) ? wrd_q : bus.b_in;
`else
    assign bus.a = bus.a_in;
    assign bus.b = bus.b_in;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Self-checking bench for regfile_write_arbiter. Inputs are driven at the
// falling edge; everything is sampled 1 ns later. Each drive step pops the
// expected write-port state for the current cycle (pushed by the previous
// step) and pushes the expectation for the next cycle from a small
// round-robin model. A behavioural register set closes the read-data loop.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int DW = 5;
    localparam int AW = 2;
    localparam int EW = 1 + AW + DW;   // {reg_en, Wr, Wrd}

    logic clk;
    logic rst;

    regfile_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // ---------------- register set stand-in ----------------
    logic [DW-1:0] regs [4];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (bus.reg_en) begin
            regs[bus.Wr] <= bus.Wrd;
        end
    end

    always_comb begin
        bus.a_in = regs[bus.Ra];
        bus.b_in = regs[bus.Rb];
    end

    // ---------------- scoreboard / model state ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur_exp;
    logic          have_exp;
    logic          exp_r0;
    logic          exp_r1;
    logic          model_pri;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    int checks   = 0;
    int failures = 0;

    // ---------------- driver ----------------
    task automatic drive(input logic r,
                         input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        logic g0;
        logic g1;
        @(negedge clk);
        rst            = r;
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        #1;
        g0 = !r && v0 && (!v1 || (model_pri == 1'b0));
        g1 = !r && v1 && (!v0 || (model_pri == 1'b1));
        exp_r0 = g0;
        exp_r1 = g1;
        if (exp_q.size() > 0) begin
            cur_exp  = exp_q.pop_front();
            have_exp = 1'b1;
        end else begin
            have_exp = 1'b0;
        end
        if (r) begin
            model_pri = 1'b0;
            last_addr = '0;
            last_data = '0;
            exp_q.push_back({1'b0, {AW{1'b0}}, {DW{1'b0}}});
        end else if (g0) begin
            model_pri = 1'b1;
            last_addr = a0;
            last_data = d0;
            exp_q.push_back({1'b1, a0, d0});
        end else if (g1) begin
            model_pri = 1'b0;
            last_addr = a1;
            last_data = d1;
            exp_q.push_back({1'b1, a1, d1});
        end else begin
            exp_q.push_back({1'b0, last_addr, last_data});
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 2'd1, 5'd3, 1'b1, 2'd2, 5'd4);
            checks++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
            end
        end
        idle();
        checks++;
        if ({bus.reg_en, bus.Wr, bus.Wrd} !== {1'b0, 2'b00, 5'b00000}) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b Wr=%b Wrd=%b want 0 00 00000", bus.reg_en, bus.Wr, bus.Wrd);
        end
        checks++;
        if (bus.pri_dbg !== 1'b0) begin
            failures++;
            $display("FAIL reset_pri: got %b want 0", bus.pri_dbg);
        end
    endtask

    task automatic test_single();
        drive(1'b0, 1'b1, 2'b00, 5'b00111, 1'b0, '0, '0);
        checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: got r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            checks++;
            if (have_exp && {bus.reg_en, bus.Wr, bus.Wrd} !== cur_exp) begin
                failures++;
                $display("FAIL single_write[%0d]: got %b want %b", i, {bus.reg_en, bus.Wr, bus.Wrd}, cur_exp);
            end
        end
        checks++;
        if ({bus.reg_en, bus.Wr, bus.Wrd} !== {1'b0, 2'b00, 5'b00111}) begin
            failures++;
            $display("FAIL single_hold: got en=%b Wr=%b Wrd=%b want 0 00 00111", bus.reg_en, bus.Wr, bus.Wrd);
        end
    endtask

    task automatic test_both_valid();
        logic [1:0] want_r;
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        bus.Ra_in = 2'b01;
        bus.Rb_in = 2'b10;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1'b0, 1'b1, 2'b01, 5'b00110, 1'b1, 2'b10, 5'b11000);
            else       idle();
            want_r = (i >= 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== want_r) begin
                failures++;
                $display("FAIL both_ready[%0d]: got r1r0=%b want %b", i, {bus.req1_ready, bus.req0_ready}, want_r);
            end
            checks++;
            if (have_exp && {bus.reg_en, bus.Wr, bus.Wrd} !== cur_exp) begin
                failures++;
                $display("FAIL both_write[%0d]: got %b want %b", i, {bus.reg_en, bus.Wr, bus.Wrd}, cur_exp);
            end
        end
        idle();
        checks++;
        if (bus.a !== 5'b00110 || bus.b !== 5'b11000) begin
            failures++;
            $display("FAIL both_readback: got a=%b b=%b want 00110 11000", bus.a, bus.b);
        end
    endtask

    task automatic test_same_addr();
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 2'b00, 5'b00000, 1'b0, '0, '0);   // moves pointer to PRI1
        bus.Ra_in = 2'b11;
        drive(1'b0, 1'b1, 2'b11, 5'b00001, 1'b1, 2'b11, 5'b11111);
        checks++;
        if (bus.pri_dbg !== 1'b1 || bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL same_first_grant: got pri=%b r0=%b r1=%b want 1 0 1", bus.pri_dbg, bus.req0_ready, bus.req1_ready);
        end
        drive(1'b0, 1'b1, 2'b11, 5'b00001, 1'b0, '0, '0);
        checks++;
        if ({bus.reg_en, bus.Wr, bus.Wrd} !== {1'b1, 2'b11, 5'b11111} || bus.req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_first_write: got en=%b Wr=%b Wrd=%b r0=%b want 1 11 11111 1", bus.reg_en, bus.Wr, bus.Wrd, bus.req0_ready);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            checks++;
            if (have_exp && {bus.reg_en, bus.Wr, bus.Wrd} !== cur_exp) begin
                failures++;
                $display("FAIL same_write[%0d]: got %b want %b", i, {bus.reg_en, bus.Wr, bus.Wrd}, cur_exp);
            end
        end
        checks++;
        if (bus.a !== 5'b00001) begin
            failures++;
            $display("FAIL same_final: got reg11=%b want 00001", bus.a);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 2'b01, 5'b01001, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0, 1'b1, 2'b11, 5'b00101);
        checks++;
        if (bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ready: got r1=%b want 0", bus.req1_ready);
        end
        checks++;
        if ({bus.reg_en, bus.Wr, bus.Wrd} !== {1'b1, 2'b01, 5'b01001}) begin
            failures++;
            $display("FAIL rstmid_presented: got en=%b Wr=%b Wrd=%b want 1 01 01001", bus.reg_en, bus.Wr, bus.Wrd);
        end
        drive(1'b0, 1'b1, 2'b00, 5'b00011, 1'b1, 2'b10, 5'b00100);
        checks++;
        if ({bus.reg_en, bus.Wr, bus.Wrd} !== {1'b0, 2'b00, 5'b00000}) begin
            failures++;
            $display("FAIL rstmid_cleared: got en=%b Wr=%b Wrd=%b want 0 00 00000", bus.reg_en, bus.Wr, bus.Wrd);
        end
        checks++;
        if (bus.pri_dbg !== 1'b0 || bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_pri: got pri=%b r0=%b r1=%b want 0 1 0", bus.pri_dbg, bus.req0_ready, bus.req1_ready);
        end
        idle();
        idle();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want_a;
`ifdef WR_BYPASS_EN
        want_a = 5'b10101;
`else
        want_a = 5'b00000;
`endif
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 2'b10, 5'b10101, 1'b0, '0, '0);
        bus.Ra_in = 2'b10;
        bus.Rb_in = 2'b01;
        idle();
        checks++;
        if ({bus.reg_en, bus.Wr, bus.Wrd} !== {1'b1, 2'b10, 5'b10101} || bus.a !== want_a || bus.b !== 5'b00000) begin
            failures++;
            $display("FAIL bypass: got en=%b Wr=%b Wrd=%b a=%b b=%b want 1 10 10101 a=%b b=00000",
                     bus.reg_en, bus.Wr, bus.Wrd, bus.a, bus.b, want_a);
        end
        idle();
        checks++;
        if (bus.a !== 5'b10101) begin
            failures++;
            $display("FAIL bypass_commit: got a=%b want 10101", bus.a);
        end
    endtask

    task automatic test_read_path();
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom_range(0, 3));
            rb = AW'($urandom_range(0, 3));
            bus.Ra_in = ra;
            bus.Rb_in = rb;
            #1;
            checks++;
            if (bus.Ra !== ra || bus.Rb !== rb) begin
                failures++;
                $display("FAIL read_addr[%0d]: got Ra=%b Rb=%b want %b %b", i, bus.Ra, bus.Rb, ra, rb);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            drive(1'b0,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), DW'($urandom_range(0, 31)));
            checks++;
            if (bus.req0_ready !== exp_r0 || bus.req1_ready !== exp_r1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got r0=%b r1=%b want %b %b", i, bus.req0_ready, bus.req1_ready, exp_r0, exp_r1);
            end
            checks++;
            if (have_exp && {bus.reg_en, bus.Wr, bus.Wrd} !== cur_exp) begin
                failures++;
                $display("FAIL b2b_write[%0d]: got %b want %b", i, {bus.reg_en, bus.Wr, bus.Wrd}, cur_exp);
            end
        end
        idle();
        checks++;
        if (have_exp && {bus.reg_en, bus.Wr, bus.Wrd} !== cur_exp) begin
            failures++;
            $display("FAIL b2b_drain: got %b want %b", {bus.reg_en, bus.Wr, bus.Wrd}, cur_exp);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.Ra_in      = '0;
        bus.Rb_in      = '0;
        model_pri      = 1'b0;
        last_addr      = '0;
        last_data      = '0;
        have_exp       = 1'b0;
        cur_exp        = '0;
        exp_r0         = 1'b0;
        exp_r1         = 1'b0;

        test_reset();
        test_single();
        test_both_valid();
        test_same_addr();
        test_reset_mid();
        test_bypass();
        test_read_path();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
